// File: rtl/fft_tpose_ctrl.sv
// Ping-pong 4x4 transpose buffer controller: steers 4-beat frames into two banks
// and drains each full bank column-by-column as an uninterrupted 4-cycle burst.
module fft_tpose_ctrl #(
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [1:0]        wr_en,
    output logic [1:0]        wr_beat,
    output logic [1:0]        rd_en,
    output logic [1:0]        rd_beat,
    output logic              out_sel,
    output logic              out_valid,
    output logic              out_last,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              err_align
);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    bank_state_t       r_bank [2];
    logic              r_wb;
    logic              r_rb;
    logic [1:0]        r_wcnt;
    logic [1:0]        r_rdBeat;
    logic [FCNT_W-1:0] r_frameCnt;
    logic              r_errAlign;
    logic              r_outValid;
    logic              r_outSel;
    logic              r_outLast;

    bank_state_t       w_bankNext [2];
    logic              w_wbNext;
    logic              w_rbNext;
    logic [1:0]        w_wcntNext;
    logic [1:0]        w_rdBeatNext;
    logic [FCNT_W-1:0] w_frameCntNext;
    logic              w_errAlignNext;
    logic              w_outValidNext;
    logic              w_outSelNext;
    logic              w_outLastNext;

    logic              w_inReady;
    logic              w_accept;
    logic              w_rdActive;
    logic [1:0]        w_row;
    logic              w_misaligned;

    assign w_inReady    = (r_bank[r_wb] == EMPTY) || (r_bank[r_wb] == FILLING);
    assign w_accept     = in_valid && w_inReady;
    // A start-of-frame always restarts the row, discarding any partial frame.
    assign w_row        = in_sof ? 2'd0 : r_wcnt;
    assign w_misaligned = (in_sof && (r_wcnt != 2'd0)) || (!in_sof && (r_wcnt == 2'd0));
    assign w_rdActive   = (r_bank[r_rb] == FULL) || (r_bank[r_rb] == DRAINING);

    assign in_ready  = w_inReady;
    assign wr_en     = w_accept ? (r_wb ? 2'b10 : 2'b01) : 2'b00;
    assign wr_beat   = w_accept ? w_row : 2'd0;
    assign rd_en     = w_rdActive ? (r_rb ? 2'b10 : 2'b01) : 2'b00;
    assign rd_beat   = r_rdBeat;
    assign out_sel   = r_outSel;
    assign out_valid = r_outValid;
    assign out_last  = r_outLast;
    assign frame_cnt = r_frameCnt;
    assign err_align = r_errAlign;

    always_comb begin
        w_bankNext[0]  = r_bank[0];
        w_bankNext[1]  = r_bank[1];
        w_wbNext       = r_wb;
        w_rbNext       = r_rb;
        w_wcntNext     = r_wcnt;
        w_rdBeatNext   = r_rdBeat;
        w_frameCntNext = r_frameCnt;
        w_errAlignNext = r_errAlign;
        w_outValidNext = w_rdActive;
        w_outSelNext   = r_rb;
        w_outLastNext  = w_rdActive && (r_rdBeat == 2'd3);

        if (w_accept) begin
            w_bankNext[r_wb] = FILLING;
            w_wcntNext       = w_row + 2'd1;
            if (w_misaligned) begin
                w_errAlignNext = 1'b1;
            end
            if (w_row == 2'd3) begin
                w_bankNext[r_wb] = FULL;
                w_wbNext         = ~r_wb;
                w_wcntNext       = 2'd0;
            end
        end

        // The write side only touches EMPTY/FILLING banks and the drain side only
        // FULL/DRAINING ones, so both updates never target the same bank state.
        if (w_rdActive) begin
            w_bankNext[r_rb] = DRAINING;
            w_rdBeatNext     = r_rdBeat + 2'd1;
            if (r_rdBeat == 2'd3) begin
                w_bankNext[r_rb] = EMPTY;
                w_rbNext         = ~r_rb;
                w_rdBeatNext     = 2'd0;
                w_frameCntNext   = r_frameCnt + FCNT_W'(1);
            end
        end

        if (clr) begin
            w_bankNext[0]  = EMPTY;
            w_bankNext[1]  = EMPTY;
            w_wbNext       = 1'b0;
            w_rbNext       = 1'b0;
            w_wcntNext     = 2'd0;
            w_rdBeatNext   = 2'd0;
            w_frameCntNext = '0;
            w_errAlignNext = 1'b0;
            w_outValidNext = 1'b0;
            w_outSelNext   = 1'b0;
            w_outLastNext  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank[0]  <= EMPTY;
            r_bank[1]  <= EMPTY;
            r_wb       <= 1'b0;
            r_rb       <= 1'b0;
            r_wcnt     <= 2'd0;
            r_rdBeat   <= 2'd0;
            r_frameCnt <= '0;
            r_errAlign <= 1'b0;
            r_outValid <= 1'b0;
            r_outSel   <= 1'b0;
            r_outLast  <= 1'b0;
        end else begin
            r_bank[0]  <= w_bankNext[0];
            r_bank[1]  <= w_bankNext[1];
            r_wb       <= w_wbNext;
            r_rb       <= w_rbNext;
            r_wcnt     <= w_wcntNext;
            r_rdBeat   <= w_rdBeatNext;
            r_frameCnt <= w_frameCntNext;
            r_errAlign <= w_errAlignNext;
            r_outValid <= w_outValidNext;
            r_outSel   <= w_outSelNext;
            r_outLast  <= w_outLastNext;
        end
    end

endmodule

// File: tb/tb_fft_tpose_ctrl.sv
// Randomized bench for fft_tpose_ctrl, checked each cycle against a frame-count
// reference model (frames written vs. frames drained, rows in flight, drain column).
module tb_fft_tpose_ctrl;

    localparam int FW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic [1:0]    wr_en;
    logic [1:0]    wr_beat;
    logic [1:0]    rd_en;
    logic [1:0]    rd_beat;
    logic          out_sel;
    logic          out_valid;
    logic          out_last;
    logic [FW-1:0] frame_cnt;
    logic          err_align;

    int errCount   = 0;
    int checkCount = 0;

    // Reference model: frames completed (mW), frames fully drained (mR),
    // rows already written in the current frame, and the column being drained.
    int mW, mR, mRows, mDrainPos;
    int mErr, mOutValid, mOutSel, mOutLast;

    fft_tpose_ctrl #(.FCNT_W(FW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_beat   (wr_beat),
        .rd_en     (rd_en),
        .rd_beat   (rd_beat),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_last  (out_last),
        .frame_cnt (frame_cnt),
        .err_align (err_align)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mW = 0; mR = 0; mRows = 0; mDrainPos = 0;
        mErr = 0; mOutValid = 0; mOutSel = 0; mOutLast = 0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"},  32'(in_ready),  32'd1);
        checkOutput({tag, "_wr_en"},     32'(wr_en),     32'd0);
        checkOutput({tag, "_wr_beat"},   32'(wr_beat),   32'd0);
        checkOutput({tag, "_rd_en"},     32'(rd_en),     32'd0);
        checkOutput({tag, "_rd_beat"},   32'(rd_beat),   32'd0);
        checkOutput({tag, "_out_sel"},   32'(out_sel),   32'd0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_out_last"},  32'(out_last),  32'd0);
        checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        checkOutput({tag, "_err_align"}, 32'(err_align), 32'd0);
    endtask

    // Called at posedge+1: drives one cycle, checks mid-cycle, advances the model.
    task automatic applyStimulus(input logic v, input logic s, input logic c);
        int expReady, accept, rdActive, row;
        in_valid = v;
        in_sof   = s;
        clr      = c;
        #4;
        expReady = ((mW - mR) < 2) ? 1 : 0;
        accept   = (v && expReady != 0) ? 1 : 0;
        rdActive = (mW > mR) ? 1 : 0;
        row      = s ? 0 : mRows;
        checkOutput("in_ready",  32'(in_ready),  32'(expReady));
        checkOutput("wr_en",     32'(wr_en),     accept ? 32'(1 << (mW % 2)) : 32'd0);
        checkOutput("wr_beat",   32'(wr_beat),   accept ? 32'(row) : 32'd0);
        checkOutput("rd_en",     32'(rd_en),     rdActive ? 32'(1 << (mR % 2)) : 32'd0);
        checkOutput("rd_beat",   32'(rd_beat),   rdActive ? 32'(mDrainPos) : 32'd0);
        checkOutput("out_valid", 32'(out_valid), 32'(mOutValid));
        checkOutput("out_sel",   32'(out_sel),   32'(mOutSel));
        checkOutput("out_last",  32'(out_last),  32'(mOutLast));
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(mR % (1 << FW)));
        checkOutput("err_align", 32'(err_align), 32'(mErr));
        if (c) begin
            modelReset();
        end else begin
            mOutValid = rdActive;
            mOutSel   = mR % 2;
            mOutLast  = (rdActive != 0 && mDrainPos == 3) ? 1 : 0;
            if (rdActive != 0) begin
                mDrainPos++;
                if (mDrainPos == 4) begin
                    mDrainPos = 0;
                    mR++;
                end
            end
            if (accept != 0) begin
                if ((s && mRows != 0) || (!s && mRows == 0)) mErr = 1;
                mRows = row + 1;
                if (mRows == 4) begin
                    mRows = 0;
                    mW++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sendFrame();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic doAsyncReset();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("asyncRst");
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic v, s, c;
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        modelReset();
        #3;
        checkResetValues("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        sendFrame();
        idle(6);
        checkOutput("singleFrameCnt", 32'(frame_cnt), 32'd1);

        for (int f = 0; f < 8; f++) sendFrame();
        idle(6);
        checkOutput("backToBackCnt", 32'(frame_cnt), 32'd9);
        checkOutput("noErrYet", 32'(err_align), 32'd0);

        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("sofBeat2Err", 32'(err_align), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        idle(6);
        checkOutput("sofBeat2Cnt", 32'(frame_cnt), 32'd10);

        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("clrErr", 32'(err_align), 32'd0);
        checkOutput("clrCnt", 32'(frame_cnt), 32'd0);

        sendFrame();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("midDrainBeat", 32'(rd_beat), 32'd1);
        doAsyncReset();
        sendFrame();
        idle(6);
        checkOutput("afterRstCnt", 32'(frame_cnt), 32'd1);

        for (int i = 0; i < 800; i++) begin
            v = ($urandom % 4) != 0;
            s = (mRows == 0) ? (($urandom % 16) != 0) : (($urandom % 16) == 0);
            c = ($urandom % 200) == 0;
            applyStimulus(v, s, c);
        end
        idle(6);

        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 40; f++) sendFrame();
        idle(6);
        checkOutput("wrapCnt", 32'(frame_cnt), 32'd8);

        sendFrame();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("midRunClrCnt", 32'(frame_cnt), 32'd0);
        checkOutput("midRunClrErr", 32'(err_align), 32'd0);
        checkOutput("midRunClrOutValid", 32'(out_valid), 32'd0);
        sendFrame();
        idle(6);

        $display("[TB] Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fft_tpose_ctrl.md
# fft_tpose_ctrl

Sequencing controller for a pair of 4x4 transpose buffers sitting between one FFT butterfly stage and the next. It accepts 4-beat frames of 136-bit data (four 34-bit complex samples per beat) under a valid/ready handshake, and steers each frame into a ping-pong bank. It then schedules the column-order drain of every full bank as a 4-cycle burst to the downstream stage. The controller also counts frames and flags alignment errors.

## Interface
- FCNT_W, 16, width of the completed-frame counter (wraps)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear: same effect as reset except on err_align and frame_cnt, which it also clears
- in_valid  in  1  butterfly beat valid
- in_sof  in  1  start-of-frame marker, qualified by in_valid
- in_ready  out  1  controller can accept a beat this cycle
- wr_en  out  2  per-bank write strobe, one-hot or zero; bit b enables bank b
- wr_beat  out  2  row index (0..3) of the beat being written
- rd_en  out  2  per-bank read strobe, one-hot or zero
- rd_beat  out  2  column index (0..3) being read
- out_sel  out  1  output mux select: the bank whose registered read data is on the bus
- out_valid  out  1  downstream data valid, aligned to registered read data
- out_last  out  1  with out_valid on column 3
- frame_cnt  out  FCNT_W  frames fully drained, modulo 2^FCNT_W
- err_align  out  1  sticky: in_sof seen on a nonzero beat, or beat 0 without in_sof

## Operation
- Each bank has its own state: EMPTY, FILLING, FULL or DRAINING. Reset puts both banks in EMPTY.
- Write pointer wb and read pointer rb are 1-bit. Both reset to 0 and each toggles per completed frame, so frames leave in arrival order.
- in_ready = (bank[wb] is EMPTY or FILLING). It is decoded from registers only, with no input-to-output combinational path.
- A beat is accepted when in_valid & in_ready. On acceptance, wr_en[wb]=1 and wr_beat=wcnt, combinationally from in_valid and the registered state.
- Write sequencing:
  - Accepting beat 0 moves the bank EMPTY->FILLING.
  - Accepting beat 3 moves it FILLING->FULL, toggles wb and sets wcnt to 0.
  - wcnt increments on each accepted beat.
- Alignment check:
  - An accepted beat with in_sof=1 and wcnt!=0 sets err_align. The beat is written as beat 0 of the same bank (row restart, wcnt becomes 1) and the partial data is discarded.
  - An accepted beat with wcnt==0 and in_sof=0 sets err_align, and the beat is written as beat 0 anyway.
- Drain sequencing:
  - When no drain is active and bank[rb] is FULL, that bank goes to DRAINING. rd_en[rb] is then asserted for 4 consecutive cycles with rd_beat 0,1,2,3.
  - After column 3 the bank returns to EMPTY, rb toggles and frame_cnt increments.
  - There is no downstream backpressure: a drain, once started, runs 4 cycles uninterrupted.
- Read data is registered in the buffer, so out_valid, out_sel and out_last are rd_en/rb/(rd_beat==3) delayed by one cycle.
- Simultaneous events:
  - Filling one bank while the other drains is the normal steady state.
  - A bank finishing its drain in cycle c is EMPTY from c+1; in_ready for that bank rises in c+1, never in c.
  - If both banks are FULL, in_ready=0 until the draining bank empties.
- Reset or clr mid-frame:
  - All partial and full frames are abandoned and both banks go to EMPTY.
  - All strobes and valids are deasserted and wcnt, rd_beat, wb and rb return to 0.
  - clr also zeroes frame_cnt and err_align. rst_n does the same asynchronously.

## Timing
- Reset values:
  - in_ready=1 (bank 0 EMPTY).
  - wr_en=0, wr_beat=0, rd_en=0, rd_beat=0, out_sel=0.
  - out_valid=0, out_last=0, frame_cnt=0, err_align=0.
- Throughput: 1 beat/cycle sustained. Back-to-back frames never stall in steady state, because each drain (4 cycles) matches a fill (4 cycles).
- Latency: beat 3 accepted at edge t gives rd_en in cycles t+1..t+4 and out_valid in cycles t+2..t+5. First output is 2 cycles after the last input beat.
- err_align sets on the edge that accepts the offending beat and holds until rst_n or clr.
- frame_cnt increments on the edge ending the column-3 read cycle, and wraps from all-ones to 0.

## Test plan
- Reset, then 1 frame of 4 beats with sof on beat 0 -> wr_en=01 with wr_beat 0..3; rd_en=01 in the 4 cycles after the last beat; out_valid 1 cycle later with out_last on the 4th; frame_cnt=1.
- 8 back-to-back frames, in_valid held high -> in_ready never drops; out_sel alternates 0/1 per frame; frame_cnt=8; data out is column-major for each frame.
- Stall the drain by filling both banks with a gap-free burst while the first drain runs -> in_ready=0 exactly until the cycle after bank 0 returns to EMPTY; no beat is lost.
- in_sof on beat 2 -> err_align=1 from that edge; the bank restarts at row 0; the next 3 beats complete the frame; frame_cnt counts only completed frames.
- rst_n asserted mid-drain at beat 1 -> all outputs go to reset values immediately; after release the next frame writes bank 0 at beat 0.
- Run 65536 frames with FCNT_W=16 -> frame_cnt wraps to 0; clr mid-run zeroes frame_cnt and err_align.
